bcd_timekeeper: RTL



---
 rtl/bcd_timekeeper.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bcd_timekeeper.sv
// Time-of-day counter for the display path: divides sys_clk to a 1 Hz tick and
// keeps hours/minutes/seconds as packed BCD in 24-hour or 12-hour (am/pm) form.
module bcd_timekeeper #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int HOUR_24       = 1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       set_valid,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       set_pm,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_tick
);

    localparam int            CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TC = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] presc;
    logic          term;
    logic          set_ok;
    logic          hr_ok;
    logic [7:0]    inc_sec, inc_min, inc_hr;
    logic          inc_pm;

    function automatic logic nib_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign term = run_en && (presc == TC);

    // Set handshake: set_valid is a single-cycle request evaluated every cycle
    // it is high (no ready); the next cycle carries exactly one set_ack or set_err.
    always_comb begin
        if (HOUR_24 != 0) begin
            hr_ok = (hr_bcd == hr_bcd) && (set_hr <= 8'h23);
        end else begin
            hr_ok = (set_hr >= 8'h01) && (set_hr <= 8'h12);
        end
        set_ok = nib_ok(set_hr) && nib_ok(set_min) && nib_ok(set_sec) &&
                 (set_sec <= 8'h59) && (set_min <= 8'h59) && hr_ok;
    end

    // One-second BCD increment with ripple carry through minutes and hours.
    always_comb begin
        inc_sec = sec_bcd;
        inc_min = min_bcd;
        inc_hr  = hr_bcd;
        inc_pm  = pm;
        if (sec_bcd[3:0] != 4'd9) begin
            inc_sec[3:0] = sec_bcd[3:0] + 4'd1;
        end else if (sec_bcd[7:4] != 4'd5) begin
            inc_sec = {sec_bcd[7:4] + 4'd1, 4'd0};
        end else begin
            inc_sec = 8'h00;
            if (min_bcd[3:0] != 4'd9) begin
                inc_min[3:0] = min_bcd[3:0] + 4'd1;
            end else if (min_bcd[7:4] != 4'd5) begin
                inc_min = {min_bcd[7:4] + 4'd1, 4'd0};
            end else begin
                inc_min = 8'h00;
                if (HOUR_24 != 0) begin
                    if (hr_bcd == 8'h23)
                        inc_hr = 8'h00;
                    else if (hr_bcd[3:0] == 4'd9)
                        inc_hr = {hr_bcd[7:4] + 4'd1, 4'd0};
                    else
                        inc_hr[3:0] = hr_bcd[3:0] + 4'd1;
                end else begin
                    // 11 -> 12 is where am/pm flips; 12 -> 01 keeps the flag.
                    if (hr_bcd == 8'h12) begin
                        inc_hr = 8'h01;
                    end else if (hr_bcd == 8'h11) begin
                        inc_hr = 8'h12;
                        inc_pm = ~pm;
                    end else if (hr_bcd[3:0] == 4'd9) begin
                        inc_hr = {hr_bcd[7:4] + 4'd1, 4'd0};
                    end else begin
                        inc_hr[3:0] = hr_bcd[3:0] + 4'd1;
                    end
                end
            end
        end
        if (HOUR_24 != 0) inc_pm = 1'b0;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            set_ack  <= 1'b0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            hr_bcd   <= (HOUR_24 != 0) ? 8'h00 : 8'h12;
            min_bcd  <= 8'h00;
            sec_bcd  <= 8'h00;
            pm       <= 1'b0;
        end else begin
            set_ack  <= 1'b0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            if (set_valid && set_ok) begin
                // A valid load overrides a coincident tick and restarts the second.
                presc   <= '0;
                set_ack <= 1'b1;
                hr_bcd  <= set_hr;
                min_bcd <= set_min;
                sec_bcd <= set_sec;
                pm      <= (HOUR_24 != 0) ? 1'b0 : set_pm;
            end else begin
                set_err <= set_valid;
                if (term) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    hr_bcd   <= inc_hr;
                    min_bcd  <= inc_min;
                    sec_bcd  <= inc_sec;
                    pm       <= inc_pm;
                end else if (run_en) begin
                    presc <= presc + CW'(1);
                end
            end
        end
    end

endmodule
